// File: rtl/hack_io_hub.sv
// Hack PC memory-mapped I/O hub: switch/button synchronisers, per-channel debouncers, W1C event latches, SEG/LED regs.
// Reads are combinational (zero latency); writes land on the clock edge; no backpressure, the CPU bus never stalls.
module hack_io_hub #(
  parameter int          N_BTN     = 5,
  parameter int          N_SW      = 16,
  parameter int          DB_CYCLES = 1_000_000,
  parameter logic [14:0] BASE_ADDR = 15'h6002
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [14:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             we,
  output logic             sel,
  output logic [15:0]      rdata,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [15:0]      seg_data,
  output logic [15:0]      led
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [2:0] OFF_SEG   = 3'd0;
  localparam logic [2:0] OFF_LED   = 3'd1;
  localparam logic [2:0] OFF_SW    = 3'd2;
  localparam logic [2:0] OFF_BTN   = 3'd3;
  localparam logic [2:0] OFF_PRESS = 3'd4;
  localparam logic [2:0] OFF_REL   = 3'd5;

  // Address decode: unsigned subtract wraps addresses below BASE_ADDR to large values.
  logic [15:0] off_full;
  logic [2:0]  off;
  logic        wr_en;

  assign off_full = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign sel      = (off_full < 16'd6);
  assign off      = off_full[2:0];
  assign wr_en    = we & sel;

  logic [N_SW-1:0]  sw_s1_q, sw_s2_q;
  logic [N_BTN-1:0] btn_s1_q, btn_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
    end
  end

  logic [N_BTN-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_BTN-1:0] press_set, rel_set;

  // A level is accepted on the DB_CYCLES-th consecutive disagreeing edge; any agreement restarts the count.
  always_comb begin
    stable_d  = stable_q;
    press_set = '0;
    rel_set   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i]  = btn_s2_q[i];
          press_set[i] = btn_s2_q[i];
          rel_set[i]   = ~btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic [15:0]      seg_q, seg_d, led_q, led_d;
  logic [N_BTN-1:0] press_q, press_d, rel_q, rel_d;
  logic [N_BTN-1:0] press_clr, rel_clr;

  // Event set is OR'd after the clear so a same-edge set survives a W1C.
  always_comb begin
    seg_d     = seg_q;
    led_d     = led_q;
    press_clr = '0;
    rel_clr   = '0;
    if (wr_en) begin
      case (off)
        OFF_SEG:   seg_d     = wdata;
        OFF_LED:   led_d     = wdata;
        OFF_PRESS: press_clr = wdata[N_BTN-1:0];
        OFF_REL:   rel_clr   = wdata[N_BTN-1:0];
        default:   ;
      endcase
    end
    press_d = (press_q & ~press_clr) | press_set;
    rel_d   = (rel_q & ~rel_clr) | rel_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q   <= '0;
      led_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      seg_q   <= seg_d;
      led_q   <= led_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_SEG:   rdata = seg_q;
        OFF_LED:   rdata = led_q;
        OFF_SW:    rdata = 16'(sw_s2_q);
        OFF_BTN:   rdata = 16'(stable_q);
        OFF_PRESS: rdata = 16'(press_q);
        OFF_REL:   rdata = 16'(rel_q);
        default:   rdata = '0;
      endcase
    end
  end

  assign seg_data = seg_q;
  assign led      = led_q;

endmodule

// File: tb/tb_hack_io_hub.sv
// Directed bench for hack_io_hub: register-map vector table plus hand sequences for sync, debounce, W1C and reset.
module tb_hack_io_hub;

  localparam logic [14:0] A_SEG   = 15'h6002;
  localparam logic [14:0] A_LED   = 15'h6003;
  localparam logic [14:0] A_SW    = 15'h6004;
  localparam logic [14:0] A_BTN   = 15'h6005;
  localparam logic [14:0] A_PRESS = 15'h6006;
  localparam logic [14:0] A_REL   = 15'h6007;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic        sel;
  logic [15:0] rdata;
  logic [4:0]  btn_raw;
  logic [15:0] sw_raw;
  logic [15:0] seg_data;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  hack_io_hub #(
    .N_BTN(5), .N_SW(16), .DB_CYCLES(4), .BASE_ADDR(15'h6002)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .we(we),
    .sel(sel), .rdata(rdata), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .seg_data(seg_data), .led(led)
  );

  typedef struct {
    logic [14:0] a;
    logic [15:0] wd;
    logic        w;
    logic        exp_sel;
    logic [15:0] exp_rd;
    logic [15:0] exp_led;
    logic [15:0] exp_seg;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rd(input string name, input logic [14:0] a, input logic [15:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{A_SEG,   16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{A_LED,   16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{A_SW,    16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[3]  = '{A_BTN,   16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[4]  = '{A_PRESS, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[5]  = '{A_REL,   16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[6]  = '{A_LED,   16'hA5A5, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[7]  = '{A_LED,   16'h0000, 1'b0, 1'b1, 16'hA5A5, 16'hA5A5, 16'h0000};
    vecs[8]  = '{A_SEG,   16'h1234, 1'b1, 1'b1, 16'h0000, 16'hA5A5, 16'h0000};
    vecs[9]  = '{A_SEG,   16'h0000, 1'b0, 1'b1, 16'h1234, 16'hA5A5, 16'h1234};
    vecs[10] = '{A_SW,    16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[11] = '{A_SW,    16'h0000, 1'b0, 1'b1, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[12] = '{A_BTN,   16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[13] = '{15'h6008, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[14] = '{15'h6001, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[15] = '{15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[16] = '{15'h7FFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[17] = '{A_LED,   16'h0000, 1'b0, 1'b1, 16'hA5A5, 16'hA5A5, 16'h1234};
    vecs[18] = '{A_SEG,   16'h0000, 1'b0, 1'b1, 16'h1234, 16'hA5A5, 16'h1234};

    reset_n = 1'b0;
    addr    = A_SEG;
    wdata   = '0;
    we      = 1'b0;
    btn_raw = '0;
    sw_raw  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", led, 16'h0000);
    chk("reset_seg", seg_data, 16'h0000);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      addr  = vecs[i].a;
      wdata = vecs[i].wd;
      we    = vecs[i].w;
      @(negedge clk);
      chk($sformatf("vec%0d_sel", i), {15'b0, sel}, {15'b0, vecs[i].exp_sel});
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      chk($sformatf("vec%0d_seg", i), seg_data, vecs[i].exp_seg);
      @(posedge clk);
      #1;
    end
    we = 1'b0;

    // Switch synchroniser: two-edge latency
    sw_raw = 16'h1234;
    addr   = A_SW;
    @(negedge clk);
    chk("sw_before_E", rdata, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("sw_after_E", rdata, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("sw_after_E1", rdata, 16'h1234);

    // Three-cycle glitch on button 2 must not be accepted
    @(posedge clk);
    #1;
    btn_raw = 5'b00100;
    repeat (3) @(posedge clk);
    #1;
    btn_raw = 5'b00000;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rd("glitch_btn", A_BTN, 16'h0000);
    rd("glitch_press", A_PRESS, 16'h0000);

    // Held press of button 2: accepted exactly at E+5
    @(posedge clk);
    #1;
    btn_raw = 5'b00100;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rd("press2_E4_btn", A_BTN, 16'h0000);
    rd("press2_E4_press", A_PRESS, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rd("press2_E5_btn", A_BTN, 16'h0004);
    rd("press2_E5_press", A_PRESS, 16'h0004);

    @(posedge clk);
    #1;
    btn_raw = 5'b00101;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rd("press0_press", A_PRESS, 16'h0005);
    rd("press0_btn", A_BTN, 16'h0005);

    wr(A_PRESS, 16'h0001);
    rd("w1c_bit0", A_PRESS, 16'h0004);

    btn_raw = 5'b00001;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rd("rel2_rel", A_REL, 16'h0004);
    rd("rel2_btn", A_BTN, 16'h0001);
    wr(A_REL, 16'hFFFF);
    rd("rel_clear_all", A_REL, 16'h0000);
    wr(A_PRESS, 16'h0004);
    rd("press_clear2", A_PRESS, 16'h0000);

    // New press of button 2 accepted on the same edge as a W1C of bit 2
    btn_raw = 5'b00101;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rd("race_pre_press", A_PRESS, 16'h0000);
    addr  = A_PRESS;
    wdata = 16'h0004;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    rd("race_set_wins", A_PRESS, 16'h0004);
    rd("race_btn", A_BTN, 16'h0005);

    // Release of button 0
    @(posedge clk);
    #1;
    btn_raw = 5'b00100;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rd("rel0_E4", A_REL, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rd("rel0_E5", A_REL, 16'h0001);
    wr(A_REL, 16'hFFFF);
    rd("rel0_cleared", A_REL, 16'h0000);
    rd("press_untouched", A_PRESS, 16'h0004);

    // Asynchronous reset mid-run with button 2 still held
    wr(A_LED, 16'hBEEF);
    rd("led_beef_rd", A_LED, 16'hBEEF);
    chk("led_beef_out", led, 16'hBEEF);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_led", led, 16'h0000);
    chk("async_rst_seg", seg_data, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    rd("post_rst_seg", A_SEG, 16'h0000);
    rd("post_rst_led", A_LED, 16'h0000);
    rd("post_rst_sw", A_SW, 16'h0000);
    rd("post_rst_btn", A_BTN, 16'h0000);
    rd("post_rst_press", A_PRESS, 16'h0000);
    rd("post_rst_rel", A_REL, 16'h0000);
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rd("held_E4_press", A_PRESS, 16'h0000);
    rd("held_E4_btn", A_BTN, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rd("held_E5_press", A_PRESS, 16'h0004);
    rd("held_E5_btn", A_BTN, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
